// File: rtl/hawk_axird_arb.sv
// hawk_axird_arb: N-to-1 AXI read arbiter; one AR in flight to the slave at a time,
// R bursts routed back in issue order through a master-index FIFO.
module hawk_axird_arb #(
  parameter int NUM_MSTR  = 2,
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 6,
  parameter int DATA_W    = 512,
  parameter int MAX_OUTST = 8,
  parameter int ARB_MODE  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_MSTR-1:0]      s_arvalid,
  output logic [NUM_MSTR-1:0]      s_arready,
  input  logic [NUM_MSTR-1:0]      s_stall,
  input  logic [NUM_MSTR*ADDR_W-1:0] s_araddr,
  input  logic [NUM_MSTR*ID_W-1:0] s_arid,
  input  logic [NUM_MSTR*8-1:0]    s_arlen,
  output logic [NUM_MSTR-1:0]      s_rvalid,
  input  logic [NUM_MSTR-1:0]      s_rready,
  output logic [DATA_W-1:0]        s_rdata,
  output logic [1:0]               s_rresp,
  output logic [ID_W-1:0]          s_rid,
  output logic                     s_rlast,
  output logic                     m_arvalid,
  input  logic                     m_arready,
  output logic [ADDR_W-1:0]        m_araddr,
  output logic [ID_W-1:0]          m_arid,
  output logic [7:0]               m_arlen,
  input  logic                     m_rvalid,
  input  logic [DATA_W-1:0]        m_rdata,
  input  logic [1:0]               m_rresp,
  input  logic [ID_W-1:0]          m_rid,
  input  logic                     m_rlast,
  output logic                     m_rready,
  output logic [$clog2(MAX_OUTST):0] outst_cnt,
  output logic                     busy
);
  localparam int IW = $clog2(NUM_MSTR);
  localparam int PW = MAX_OUTST > 1 ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST) + 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_d;
  logic [IW-1:0] ptr, win, head_m;
  logic [IW-1:0] route [MAX_OUTST];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic [NUM_MSTR-1:0] elig;
  logic accept, empty, full, pop;
  int idx;
  assign elig      = s_arvalid & ~s_stall;
  assign empty     = cnt == '0;
  assign full      = cnt == CW'(MAX_OUTST);
  assign accept    = state == IDLE && |elig && !full;
  assign head_m    = route[rd_ptr];
  assign m_rready  = !empty && s_rready[head_m];
  assign pop       = !empty && m_rvalid && m_rready && m_rlast;
  assign m_arvalid = state == ISSUE;
  assign outst_cnt = cnt;
  assign busy      = !empty || m_arvalid;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rid     = m_rid;
  assign s_rlast   = m_rlast;
  // Scan from farthest to nearest so the candidate closest to the start point wins.
  always_comb begin
    win = '0;
    idx = 0;
    for (int k = NUM_MSTR - 1; k >= 0; k--) begin
      idx = ARB_MODE == 1 ? (int'(ptr) + k) % NUM_MSTR : k;
      if (elig[IW'(idx)]) win = IW'(idx);
    end
  end
  always_comb begin
    s_arready = '0;
    s_rvalid  = '0;
    if (accept) s_arready[win] = 1'b1;
    if (!empty) s_rvalid[head_m] = m_rvalid;
  end
  always_comb state_d = state == IDLE ? (accept ? ISSUE : IDLE) : (m_arready ? IDLE : ISSUE);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      m_araddr <= '0;
      m_arid   <= '0;
      m_arlen  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt + CW'(accept) - CW'(pop);
      if (accept) begin
        m_araddr <= s_araddr[int'(win)*ADDR_W +: ADDR_W];
        m_arid   <= s_arid[int'(win)*ID_W +: ID_W];
        m_arlen  <= s_arlen[int'(win)*8 +: 8];
        ptr      <= int'(win) == NUM_MSTR - 1 ? '0 : win + 1'b1;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  // Routing entries are qualified by the reset-cleared pointers, so they need no reset.
  always_ff @(posedge clk)
    if (accept) route[wr_ptr] <= win;
endmodule

// File: tb/tb_hawk_axird_arb.sv
// tb_hawk_axird_arb: directed cycle table on a 2-master round-robin instance plus
// hand sequences for async reset and a 3-master fixed-priority instance.
module tb_hawk_axird_arb;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;

  logic [1:0]  rr_arv = '0, rr_stall = '0, rr_sarr, rr_srv, rr_srr = '0;
  logic        rr_mar = 0, rr_marv, rr_rv = 0, rr_rl = 0, rr_mrr, rr_srl, rr_busy;
  logic [31:0] rr_araddr = {16'h1001, 16'h1000}, rr_srdata, rr_mardata = 32'hdead_beef;
  logic [7:0]  rr_arid = {4'd2, 4'd1}, rr_marlen;
  logic [15:0] rr_arlen = {8'd3, 8'd0}, rr_maraddr;
  logic [3:0]  rr_marid, rr_srid;
  logic [1:0]  rr_srresp;
  logic [2:0]  rr_cnt;

  hawk_axird_arb #(.NUM_MSTR(2), .ADDR_W(16), .ID_W(4), .DATA_W(32), .MAX_OUTST(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .s_arvalid(rr_arv), .s_arready(rr_sarr), .s_stall(rr_stall),
    .s_araddr(rr_araddr), .s_arid(rr_arid), .s_arlen(rr_arlen), .s_rvalid(rr_srv), .s_rready(rr_srr),
    .s_rdata(rr_srdata), .s_rresp(rr_srresp), .s_rid(rr_srid), .s_rlast(rr_srl),
    .m_arvalid(rr_marv), .m_arready(rr_mar), .m_araddr(rr_maraddr), .m_arid(rr_marid), .m_arlen(rr_marlen),
    .m_rvalid(rr_rv), .m_rdata(rr_mardata), .m_rresp(2'b00), .m_rid(4'd0), .m_rlast(rr_rl),
    .m_rready(rr_mrr), .outst_cnt(rr_cnt), .busy(rr_busy));

  logic [2:0]  fp_arv = '0, fp_stall = '0, fp_sarr, fp_srv;
  logic        fp_marv, fp_mrr, fp_srl, fp_busy;
  logic [47:0] fp_araddr = {16'h2002, 16'h2001, 16'h2000};
  logic [11:0] fp_arid = {4'd3, 4'd2, 4'd1};
  logic [23:0] fp_arlen = '0;
  logic [15:0] fp_maraddr;
  logic [3:0]  fp_marid, fp_srid;
  logic [7:0]  fp_marlen;
  logic [31:0] fp_srdata;
  logic [1:0]  fp_srresp;
  logic [3:0]  fp_cnt;

  hawk_axird_arb #(.NUM_MSTR(3), .ADDR_W(16), .ID_W(4), .DATA_W(32), .MAX_OUTST(8), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst(rst), .s_arvalid(fp_arv), .s_arready(fp_sarr), .s_stall(fp_stall),
    .s_araddr(fp_araddr), .s_arid(fp_arid), .s_arlen(fp_arlen), .s_rvalid(fp_srv), .s_rready(3'b111),
    .s_rdata(fp_srdata), .s_rresp(fp_srresp), .s_rid(fp_srid), .s_rlast(fp_srl),
    .m_arvalid(fp_marv), .m_arready(1'b1), .m_araddr(fp_maraddr), .m_arid(fp_marid), .m_arlen(fp_marlen),
    .m_rvalid(1'b1), .m_rdata(32'h0), .m_rresp(2'b00), .m_rid(4'd0), .m_rlast(1'b1),
    .m_rready(fp_mrr), .outst_cnt(fp_cnt), .busy(fp_busy));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] arv, stall;
    logic       mar, rv, rl;
    logic [1:0] rr, e_sarr;
    logic       e_marv;
    logic [3:0] e_arid;
    logic [2:0] e_cnt;
    logic [1:0] e_srv;
    logic       e_mrr;
  } vec_t;
  vec_t tv[$];

  initial begin
    // arv stall mar rv rl rr | sarr marv arid cnt srv mrr
    tv.push_back('{2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b01, 0, 4'd0, 3'd0, 2'b00, 0});
    tv.push_back('{2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 4'd1, 3'd1, 2'b00, 0});
    tv.push_back('{2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b10, 0, 4'd0, 3'd1, 2'b00, 0});
    tv.push_back('{2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 4'd2, 3'd2, 2'b00, 0});
    tv.push_back('{2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b01, 0, 4'd0, 3'd2, 2'b00, 0});
    tv.push_back('{2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 4'd1, 3'd3, 2'b00, 0});
    tv.push_back('{2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b10, 0, 4'd0, 3'd3, 2'b00, 0});
    tv.push_back('{2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 4'd2, 3'd4, 2'b00, 0});
    tv.push_back('{2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 4'd0, 3'd4, 2'b00, 0});
    tv.push_back('{2'b11, 2'b00, 1, 1, 1, 2'b01, 2'b00, 0, 4'd0, 3'd4, 2'b01, 1});
    tv.push_back('{2'b11, 2'b00, 1, 0, 0, 2'b00, 2'b01, 0, 4'd0, 3'd3, 2'b00, 0});
    tv.push_back('{2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 4'd1, 3'd4, 2'b00, 0});
    tv.push_back('{2'b11, 2'b11, 0, 0, 0, 2'b00, 2'b00, 1, 4'd1, 3'd4, 2'b00, 0});
    tv.push_back('{2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 1, 4'd1, 3'd4, 2'b00, 0});
    tv.push_back('{2'b00, 2'b00, 0, 1, 0, 2'b10, 2'b00, 0, 4'd0, 3'd4, 2'b10, 1});
    tv.push_back('{2'b00, 2'b00, 0, 1, 0, 2'b10, 2'b00, 0, 4'd0, 3'd4, 2'b10, 1});
    tv.push_back('{2'b00, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 4'd0, 3'd4, 2'b10, 0});
    tv.push_back('{2'b00, 2'b00, 0, 1, 0, 2'b10, 2'b00, 0, 4'd0, 3'd4, 2'b10, 1});
    tv.push_back('{2'b00, 2'b00, 0, 1, 1, 2'b10, 2'b00, 0, 4'd0, 3'd4, 2'b10, 1});
    tv.push_back('{2'b00, 2'b00, 0, 1, 1, 2'b10, 2'b00, 0, 4'd0, 3'd3, 2'b01, 0});
    tv.push_back('{2'b00, 2'b00, 0, 1, 1, 2'b01, 2'b00, 0, 4'd0, 3'd3, 2'b01, 1});
    tv.push_back('{2'b01, 2'b00, 1, 1, 1, 2'b10, 2'b01, 0, 4'd0, 3'd2, 2'b10, 1});
    tv.push_back('{2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 1, 4'd1, 3'd2, 2'b00, 0});

    repeat (2) @(negedge clk);
    #1;
    chk("rst m_arvalid", 32'(rr_marv), 0);
    chk("rst outst_cnt", 32'(rr_cnt), 0);
    chk("rst busy", 32'(rr_busy), 0);
    chk("rst m_arid", 32'(rr_marid), 0);
    chk("rst m_araddr", 32'(rr_maraddr), 0);
    chk("rst s_arready", 32'(rr_sarr), 0);
    chk("rst m_rready", 32'(rr_mrr), 0);
    rst = 0;

    foreach (tv[i]) begin
      @(negedge clk);
      rr_arv = tv[i].arv; rr_stall = tv[i].stall; rr_mar = tv[i].mar;
      rr_rv = tv[i].rv; rr_rl = tv[i].rl; rr_srr = tv[i].rr;
      #1;
      chk($sformatf("c%0d s_arready", i), 32'(rr_sarr), 32'(tv[i].e_sarr));
      chk($sformatf("c%0d m_arvalid", i), 32'(rr_marv), 32'(tv[i].e_marv));
      chk($sformatf("c%0d outst_cnt", i), 32'(rr_cnt), 32'(tv[i].e_cnt));
      chk($sformatf("c%0d s_rvalid", i), 32'(rr_srv), 32'(tv[i].e_srv));
      chk($sformatf("c%0d m_rready", i), 32'(rr_mrr), 32'(tv[i].e_mrr));
      if (tv[i].e_marv) begin
        chk($sformatf("c%0d m_arid", i), 32'(rr_marid), 32'(tv[i].e_arid));
        chk($sformatf("c%0d m_arlen", i), 32'(rr_marlen), tv[i].e_arid == 4'd2 ? 32'd3 : 32'd0);
        chk($sformatf("c%0d m_araddr", i), 32'(rr_maraddr), 32'h0fff + 32'(tv[i].e_arid));
      end
    end

    // Asynchronous reset while an AR is being issued, checked before the next edge
    #1 rst = 1;
    #1;
    chk("arst m_arvalid", 32'(rr_marv), 0);
    chk("arst outst_cnt", 32'(rr_cnt), 0);
    chk("arst busy", 32'(rr_busy), 0);
    @(negedge clk);
    rst = 0; rr_arv = 2'b00; rr_rv = 1; rr_rl = 1; rr_srr = 2'b11;
    #1;
    chk("stray s_rvalid", 32'(rr_srv), 0);
    chk("stray m_rready", 32'(rr_mrr), 0);
    @(negedge clk);
    rr_arv = 2'b11; rr_rv = 0; rr_rl = 0; rr_srr = 2'b00;
    #1;
    chk("post-rst grant", 32'(rr_sarr), 32'b01);
    @(negedge clk);
    rr_arv = 2'b00;

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      fp_arv = 3'b101;
      #1;
      chk($sformatf("fp k%0d s_arready", k), 32'(fp_sarr), k % 2 == 0 ? 32'b001 : 32'b000);
      chk($sformatf("fp k%0d m_arvalid", k), 32'(fp_marv), 32'(k % 2));
    end
    @(negedge clk);
    fp_stall = 3'b001;
    #1;
    chk("fp stall0 grant", 32'(fp_sarr), 32'b100);
    @(negedge clk);
    #1;
    chk("fp m2 m_arvalid", 32'(fp_marv), 1);
    chk("fp m2 m_arid", 32'(fp_marid), 3);
    fp_arv = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hawk_axird_arb.md
HAWK_AXIRD_ARB -- requirements
Module: hawk_axird_arb

Interface
REQ-001 SHALL have parameter NUM_MSTR, default 2, number of AXI read masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 64, AR address width.
REQ-003 SHALL have parameter ID_W, default 6, AR/R ID width, passed through unmodified.
REQ-004 SHALL have parameter DATA_W, default 512, R data width.
REQ-005 SHALL have parameter MAX_OUTST, default 8, route-FIFO depth, power of two.
REQ-006 SHALL have parameter ARB_MODE, default 1; 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-007 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-009 SHALL have ports s_arvalid, s_arready, s_stall: input/output/input, NUM_MSTR each; per-master AR handshake and per-master request mask.
REQ-010 SHALL have ports s_araddr, s_arid, s_arlen: input, NUM_MSTR*ADDR_W, NUM_MSTR*ID_W, NUM_MSTR*8; packed, master i at slice i.
REQ-011 SHALL have ports s_rvalid (output, NUM_MSTR) and s_rready (input, NUM_MSTR), per-master R handshake.
REQ-012 SHALL have ports s_rdata, s_rresp, s_rid, s_rlast: output, DATA_W, 2, ID_W, 1; broadcast copies of m_r*.
REQ-013 SHALL have ports m_arvalid (output, 1), m_arready (input, 1), m_araddr (output, ADDR_W), m_arid (output, ID_W), m_arlen (output, 8): downstream AR.
REQ-014 SHALL have ports m_rvalid, m_rdata, m_rresp, m_rid, m_rlast (input, 1/DATA_W/2/ID_W/1) and m_rready (output, 1): downstream R.
REQ-015 SHALL have ports outst_cnt (output, clog2(MAX_OUTST)+1, bursts in flight) and busy (output, 1, outst_cnt!=0 or m_arvalid).

Function
REQ-016 SHALL implement two-state AR FSM: IDLE, ISSUE.
REQ-017 In IDLE, eligible(i) = s_arvalid[i] & ~s_stall[i]; SHALL accept only when any eligible and route FIFO not full.
REQ-018 On accept, SHALL assert s_arready[winner] combinationally that cycle only, register winner's addr/id/len into m_ar*, push winner index into route FIFO, enter ISSUE.
REQ-019 s_arready SHALL be one-hot or zero; never asserted in ISSUE, when FIFO full, or for a stalled master.
REQ-020 In ISSUE, m_arvalid SHALL be 1 with m_ar* stable until m_arready; on handshake SHALL return to IDLE next cycle.
REQ-021 Accept-to-m_arvalid latency SHALL be 1 cycle; max AR throughput one burst per 2 cycles.
REQ-022 ARB_MODE=1: priority pointer SHALL start at 0 and, on each accept, move to (winner+1) mod NUM_MSTR; search starts at pointer.
REQ-023 ARB_MODE=0: pointer unused; lowest eligible index SHALL win.
REQ-024 Route FIFO: in-order, depth MAX_OUTST; pointers wrap mod MAX_OUTST; outst_cnt = entries.
REQ-025 FIFO empty: m_rready SHALL be 0 and all s_rvalid 0 (stray R beats stall).
REQ-026 FIFO non-empty with head h: s_rvalid[h]=m_rvalid, others 0; m_rready=s_rready[h].
REQ-027 Pop SHALL occur on m_rvalid & m_rready & m_rlast; non-last beats do not pop.
REQ-028 Simultaneous push and pop SHALL leave outst_cnt unchanged; pop from full SHALL permit accept the next cycle, not the same cycle.
REQ-029 s_stall asserted during ISSUE SHALL not cancel the issued request.

Reset
REQ-030 rst SHALL asynchronously force IDLE, m_arvalid=0, m_ar* =0, pointer=0, FIFO empty, outst_cnt=0, busy=0, m_rready=0, all s_arready/s_rvalid=0.
REQ-031 Reset mid-burst SHALL discard routing; bursts in flight are not completed.

Verification
REQ-032 NUM_MSTR=2, ARB_MODE=1: both s_arvalid held high -> grants 0,1,0,1; m_arvalid 1 cycle after each s_arready.
REQ-033 ARB_MODE=0, masters 0 and 2 valid continuously -> master 0 always granted, master 2 starves; set s_stall[0]=1 -> master 2 granted next IDLE cycle.
REQ-034 MAX_OUTST=4, no R returned: 4 accepts then s_arready stays 0, outst_cnt=4; one rlast beat -> outst_cnt=3, next accept 1 cycle later.
REQ-035 Grants M1 (arlen=3) then M0 (arlen=0): 4 beats to s_rvalid[1] only, pop on 4th; then 1 beat to M0; s_rready[1]=0 mid-burst -> m_rready=0.
REQ-036 Push and rlast pop same cycle at outst_cnt=2 -> remains 2; rst asserted during ISSUE -> m_arvalid=0 and outst_cnt=0 immediately, without a clock edge.
